iterative_divider24: RTL
========================

# iterative_divider24

Sequential 24-bit integer divider producing quotient and remainder, signed or unsigned, one operation in flight. It is the inverse-operation companion to the pipelined radix-4 Booth/Wallace 24-bit multiplier and shares its operand conventions (`signedFlag`, M-bit operands, `clk`). It sits beside the multiplier in the ALU/FPU datapath, for example for mantissa division. It uses a start/busy/done handshake instead of a fixed pipeline.

## Interface
- `M`, 24, operand width (quotient and remainder also M bits)
- `clk`  in  1  rising-edge clock
- `resetN`  in  1  synchronous active-low reset
- `start`  in  1  request; sampled only when idle
- `signedFlag`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`
- `dividend`  in  M  numerator; sampled with `start`
- `divisor`  in  M  denominator; sampled with `start`
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse; results valid
- `quotient`  out  M  result quotient, held until next completion
- `remainder`  out  M  result remainder, held until next completion
- `divByZero`  out  1  set with `done` if divisor was 0; held with results

## Operation
- States: IDLE, ITER, FIX.
- **IDLE**
  - `start`=1 accepts the operation.
  - Latch sign of dividend (sd) and sign of divisor (sv). Both are 0 when unsigned.
  - Latch magnitudes |dividend| and |divisor|. |−2^(M−1)| = 2^(M−1) fits unsigned in M bits.
  - Clear iteration counter, set partial remainder to 0. Go to ITER.
- **ITER** (exactly M cycles)
  - Radix-2 non-restoring step per cycle on an (M+1)-bit signed partial remainder.
  - Shift in the next dividend magnitude bit, MSB first.
  - If the partial remainder is ≥0, subtract the divisor magnitude; otherwise add it.
  - Quotient bit = NOT sign of the new partial remainder.
  - Go to FIX after the counter reaches M−1.
- **FIX** (1 cycle)
  - If the partial remainder is negative, add the divisor magnitude back.
  - Quotient = magnitude, negated if sd XOR sv.
  - Remainder = magnitude, negated if sd. Division truncates toward zero; the remainder takes the dividend's sign.
  - Register outputs, pulse `done`, return to IDLE.
- **Divisor = 0**
  - Regardless of `signedFlag`: quotient = all ones, remainder = original dividend, divByZero=1.
- **Overflow**
  - Signed −2^(M−1) / −1 gives quotient 0x800000, remainder 0, divByZero=0. Two's-complement wrap, no flag.
- `start` while `busy`=1 is ignored.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- Reset (`resetN`=0 at a rising edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `divByZero`=0.
  - Reset mid-operation aborts it with no `done` pulse.
- Accept edge E0 (IDLE, `start`=1): `busy`=1 from E0 through E(M+1).
- ITER occupies edges E1..EM. FIX completes at E(M+1).
- After E(M+1): `done`=1 for one cycle, `busy`=0, results valid. Latency is M+1 = 25 cycles from the accept edge.
- Back-to-back: `start`=1 in the `done` cycle is accepted at that edge. Maximum throughput is one divide per M+1 cycles.
- `done` and `busy` are never both 1.
- Outputs change only at a completion edge or at reset.

## Configuration
- `DIV_ZERO_BYPASS_EN` defined:
  - A zero divisor is detected in IDLE at accept.
  - The block goes directly to FIX, forces the divide-by-zero results, and `done` pulses after E1.
  - Latency is 1 cycle; `busy`=1 only from E0 to E1.
- Not defined: a zero divisor takes the full M+1 cycles, with FIX forcing the results. Latency is constant for all operands.

## Test plan
- Unsigned 1000 / 7 → quotient 142, remainder 6, divByZero 0. `done` exactly 25 cycles after accept; `busy` high for 25 cycles.
- Signed sign combinations:
  - 0xFFFFF9 / 2 (−7/2) → q 0xFFFFFD (−3), r 0xFFFFFF (−1)
  - 7 / 0xFFFFFE → q 0xFFFFFD, r 1
  - 0xFFFFF9 / 0xFFFFFE → q 3, r 0xFFFFFF
- Extremes:
  - Unsigned 0xFFFFFF / 0xFFFFFF → q 1, r 0
  - Unsigned 0xFFFFFF / 1 → q 0xFFFFFF, r 0
  - Signed 0x800000 / 0xFFFFFF → q 0x800000, r 0
- Divide by zero: 0x123456 / 0 (signed and unsigned) → q 0xFFFFFF, r 0x123456, divByZero 1. Latency 25, or 1 with `DIV_ZERO_BYPASS_EN`.
- Handshake: `start` re-asserted with new operands at cycle 10 of an operation → ignored, first result unchanged. `start` held in the `done` cycle → second op accepted, `done` again 25 cycles later.
- Reset: `resetN`=0 at iteration 12 → after the next edge all outputs are 0, no `done`. A following 100/10 completes with q 10, r 0.
- Sweep: loop i, j over 0..0xFFFFFF with step 0xFFFF, both `signedFlag` values. Compare against the behavioural `/` and `%` model (divisor-0 cases use the rule above).

Source files
------------

// File: rtl/iterative_divider24.sv
// Sequential M-bit signed/unsigned divider: radix-2 non-restoring, one op in flight,
// start/busy/done handshake. Optional `DIV_ZERO_BYPASS_EN finishes divide-by-zero in one cycle.
module iterative_divider24 #(
  parameter int unsigned M = 24
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         start,
  input  logic         signedFlag,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         divByZero
);

  localparam int unsigned CW = $clog2(M);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [M:0]     pr;
  logic [M-1:0]   qreg;
  logic [M-1:0]   dvs;
  logic [M-1:0]   orig;
  logic           sd;
  logic           sv;
  logic           dz;

  logic           sd_in;
  logic           sv_in;
  logic [M-1:0]   dvd_in_mag;
  logic [M-1:0]   dvs_in_mag;
  logic [M:0]     shifted;
  logic [M:0]     stepped;
  logic [M-1:0]   rem_mag;
  logic [M-1:0]   q_res;
  logic [M-1:0]   r_res;

  // Operand magnitudes, one non-restoring step, and final sign correction.
  // The partial remainder stays within [-|d|, |d|), so M+1-bit modular arithmetic is exact.
  always_comb begin
    sd_in      = signedFlag & dividend[M-1];
    sv_in      = signedFlag & divisor[M-1];
    dvd_in_mag = sd_in ? -dividend : dividend;
    dvs_in_mag = sv_in ? -divisor : divisor;
    shifted    = {pr[M-1:0], qreg[M-1]};
    stepped    = pr[M] ? (shifted + {1'b0, dvs}) : (shifted - {1'b0, dvs});
    rem_mag    = pr[M] ? (pr[M-1:0] + dvs) : pr[M-1:0];
    q_res      = (sd ^ sv) ? -qreg : qreg;
    r_res      = sd ? -rem_mag : rem_mag;
    if (dz) begin
      q_res = '1;
      r_res = orig;
    end
  end

  // qreg shifts dividend bits out at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
      cnt       <= '0;
      pr        <= '0;
      qreg      <= '0;
      dvs       <= '0;
      orig      <= '0;
      sd        <= 1'b0;
      sv        <= 1'b0;
      dz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sd   <= sd_in;
            sv   <= sv_in;
            qreg <= dvd_in_mag;
            dvs  <= dvs_in_mag;
            orig <= dividend;
            dz   <= (divisor == '0);
            cnt  <= '0;
            pr   <= '0;
            busy <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            state <= (divisor == '0) ? FIX : ITER;
`else
            state <= ITER;
`endif
          end
        end
        ITER: begin
          pr   <= stepped;
          qreg <= {qreg[M-2:0], ~stepped[M]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(M - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= q_res;
          remainder <= r_res;
          divByZero <= dz;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
